krnl_card_rtl_axi_read_master: RTL and testbench

// - AXI4 read master: fetches ctrl_length 64-bit words from gmem at ctrl_offset, emits them in order on an AXI4-Stream master.
// - Read-side counterpart of the kernel write master; same ctrl_start/ctrl_done control contract, driven from the control s_axi block.
// - Internal data FIFO with credit accounting: AR issued only when a whole burst fits, so rready never stalls the interconnect.

---
 rtl/krnl_card_rtl_axi_read_master.sv | 173 +++++++++++++++++
 tb/tb_krnl_card_rtl_axi_read_master.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/krnl_card_rtl_axi_read_master.sv
// AXI4 read master: fetches ctrl_length 64-bit beats from gmem at ctrl_offset and
// streams them out in address order on an AXI4-Stream master.
// A credit counter mirrors free FIFO space, and a burst is requested only once all of
// its beats are guaranteed room, so rready can stay high permanently.
// Optional feature macro: KRNL_CARD_RTL_RRESP_ERR_EN adds a sticky rresp_err output.
module krnl_card_rtl_axi_read_master #(
  parameter int C_ADDR_WIDTH       = 64,
  parameter int C_DATA_WIDTH       = 64,
  parameter int C_BURST_LEN        = 256,
  parameter int C_LOG_BURST_LEN    = 8,
  parameter int C_MAX_LENGTH_WIDTH = 32,
  parameter int C_FIFO_DEPTH       = 512
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          ctrl_start,
  input  logic [C_ADDR_WIDTH-1:0]       ctrl_offset,
  input  logic [C_MAX_LENGTH_WIDTH-1:0] ctrl_length,
  output logic                          ctrl_done,
  output logic                          arvalid,
  input  logic                          arready,
  output logic [C_ADDR_WIDTH-1:0]       araddr,
  output logic [7:0]                    arlen,
  output logic [2:0]                    arsize,
  input  logic                          rvalid,
  output logic                          rready,
  input  logic [C_DATA_WIDTH-1:0]       rdata,
  input  logic                          rlast,
  input  logic [1:0]                    rresp,
  output logic                          m_tvalid,
  input  logic                          m_tready,
  output logic [C_DATA_WIDTH-1:0]       m_tdata
`ifdef KRNL_CARD_RTL_RRESP_ERR_EN
  ,
  output logic                          rresp_err
`endif
);

  localparam int FIFO_AW     = $clog2(C_FIFO_DEPTH);
  localparam int CNT_W       = FIFO_AW + 1;
  localparam int BURST_W     = C_MAX_LENGTH_WIDTH - C_LOG_BURST_LEN + 1;
  localparam int BEAT_W      = C_LOG_BURST_LEN + 1;
  localparam int BURST_BYTES = C_BURST_LEN * C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                        state_q, state_d;
  logic [C_MAX_LENGTH_WIDTH-1:0] len_q, popped_q;
  logic [C_ADDR_WIDTH-1:0]       addr_q, araddr_q;
  logic [BURST_W-1:0]            bursts_q, bursts_init;
  logic [C_LOG_BURST_LEN-1:0]    last_rem_q;
  logic [CNT_W-1:0]              credits_q, credits_d;
  logic [CNT_W-1:0]              wr_ptr_q, rd_ptr_q;
  logic [BEAT_W-1:0]             burst_beats;
  logic [7:0]                    arlen_q;
  logic                          arvalid_q, rready_q;
  logic                          start_ok, r_fire, pop, ar_fire, ar_raise;
  logic [C_DATA_WIDTH-1:0]       mem [C_FIFO_DEPTH];

  // rlast is not needed: beats are counted, not framed
  logic unused_ok;
  assign unused_ok = ^{rlast, rresp};

  assign start_ok = (state_q == StIdle) && ctrl_start;
  assign r_fire   = rvalid && rready_q;
  assign pop      = m_tvalid && m_tready;
  assign ar_fire  = arvalid_q && arready;

  assign bursts_init = BURST_W'(ctrl_length >> C_LOG_BURST_LEN)
                     + BURST_W'(|ctrl_length[C_LOG_BURST_LEN-1:0]);

  // Only the final burst may be short
  assign burst_beats = (bursts_q == BURST_W'(1) && last_rem_q != '0) ? BEAT_W'(last_rem_q)
                                                                       : BEAT_W'(C_BURST_LEN);
  assign ar_raise = (state_q == StRun) && !arvalid_q && (bursts_q != '0)
                 && (credits_q >= CNT_W'(burst_beats));

  assign arvalid   = arvalid_q;
  assign araddr    = araddr_q;
  assign arlen     = arlen_q;
  assign arsize    = 3'($clog2(C_DATA_WIDTH / 8));
  assign rready    = rready_q;
  assign m_tvalid  = (wr_ptr_q != rd_ptr_q);
  assign m_tdata   = mem[rd_ptr_q[FIFO_AW-1:0]];
  assign ctrl_done = (state_q == StDone);

  // Next-state logic and credit bookkeeping (return and debit may coincide)
  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    if (pop)      credits_d = credits_d + CNT_W'(1);
    if (ar_raise) credits_d = credits_d - CNT_W'(burst_beats);
    case (state_q)
      StIdle: if (ctrl_start) state_d = (ctrl_length == '0) ? StDone : StRun;
      StRun:  if (pop && popped_q == len_q - C_MAX_LENGTH_WIDTH'(1)) state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state: FSM, latched command, popped-beat counter, credits
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= StIdle;
      len_q      <= '0;
      popped_q   <= '0;
      last_rem_q <= '0;
      credits_q  <= CNT_W'(C_FIFO_DEPTH);
      rready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      credits_q <= credits_d;
      rready_q  <= 1'b1;
      if (start_ok) begin
        len_q      <= ctrl_length;
        last_rem_q <= ctrl_length[C_LOG_BURST_LEN-1:0];
        popped_q   <= '0;
      end else if (pop) begin
        popped_q <= popped_q + C_MAX_LENGTH_WIDTH'(1);
      end
    end
  end

  // AR channel: raise when a whole burst fits, hold stable until accepted
  always_ff @(posedge aclk) begin
    if (areset) begin
      addr_q    <= '0;
      bursts_q  <= '0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      arlen_q   <= '0;
    end else if (start_ok) begin
      addr_q   <= ctrl_offset;
      bursts_q <= bursts_init;
    end else if (ar_raise) begin
      arvalid_q <= 1'b1;
      araddr_q  <= addr_q;
      arlen_q   <= 8'(burst_beats - BEAT_W'(1));
    end else if (ar_fire) begin
      arvalid_q <= 1'b0;
      addr_q    <= addr_q + C_ADDR_WIDTH'(BURST_BYTES);
      bursts_q  <= bursts_q - BURST_W'(1);
    end
  end

  // FIFO pointers; the extra MSB distinguishes full from empty
  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (r_fire) wr_ptr_q <= wr_ptr_q + CNT_W'(1);
      if (pop)    rd_ptr_q <= rd_ptr_q + CNT_W'(1);
    end
  end

  // FIFO storage, no reset needed
  always_ff @(posedge aclk) begin
    if (r_fire) mem[wr_ptr_q[FIFO_AW-1:0]] <= rdata;
  end

`ifdef KRNL_CARD_RTL_RRESP_ERR_EN
  logic rresp_err_q;
  assign rresp_err = rresp_err_q;

  // Sticky error flag, cleared per transfer
  always_ff @(posedge aclk) begin
    if (areset || start_ok) rresp_err_q <= 1'b0;
    else if (r_fire && rresp != 2'b00) rresp_err_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_krnl_card_rtl_axi_read_master.sv
// Bench for krnl_card_rtl_axi_read_master: AXI slave memory model, transfer-level
// reference model checked every cycle, and directed scenarios with literal checks.
module tb_krnl_card_rtl_axi_read_master;
  localparam int AW = 64;
  localparam int DW = 64;
  localparam int LW = 32;

  logic          aclk = 1'b0;
  logic          areset = 1'b1;
  logic          ctrl_start = 1'b0;
  logic [AW-1:0] ctrl_offset = '0;
  logic [LW-1:0] ctrl_length = '0;
  logic          ctrl_done;
  logic          arvalid;
  logic          arready = 1'b0;
  logic [AW-1:0] araddr;
  logic [7:0]    arlen;
  logic [2:0]    arsize;
  logic          rvalid = 1'b0;
  logic          rready;
  logic [DW-1:0] rdata = '0;
  logic          rlast = 1'b0;
  logic [1:0]    rresp = 2'b00;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
`ifdef KRNL_CARD_RTL_RRESP_ERR_EN
  logic          rresp_err;
`endif

  int cmp_cnt = 0;
  int err_cnt = 0;

  int          ar_mode = 1;
  int          m_mode = 1;
  logic [63:0] err_addr = '1;

  int          ar_cnt = 0, beat_cnt = 0, done_cnt = 0, rready_low_cnt = 0;
  logic [63:0] ar_log_addr[$];
  int          ar_log_len[$];

  krnl_card_rtl_axi_read_master dut (
    .aclk        (aclk),
    .areset      (areset),
    .ctrl_start  (ctrl_start),
    .ctrl_offset (ctrl_offset),
    .ctrl_length (ctrl_length),
    .ctrl_done   (ctrl_done),
    .arvalid     (arvalid),
    .arready     (arready),
    .araddr      (araddr),
    .arlen       (arlen),
    .arsize      (arsize),
    .rvalid      (rvalid),
    .rready      (rready),
    .rdata       (rdata),
    .rlast       (rlast),
    .rresp       (rresp),
    .m_tvalid    (m_tvalid),
    .m_tready    (m_tready),
    .m_tdata     (m_tdata)
`ifdef KRNL_CARD_RTL_RRESP_ERR_EN
    ,
    .rresp_err   (rresp_err)
`endif
  );

  initial forever #5 aclk = ~aclk;

  function automatic logic [63:0] mdata(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_C3C3, a[31:0] + 32'h1234_0000};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Memory slave: queues beats per accepted AR, returns them in order
  logic [63:0] pend_addr[$];
  bit          pend_last[$];
  initial begin
    int          cyc;
    bit          ar_hs, r_hs, rst;
    logic [63:0] a_addr;
    int          a_len;
    cyc = 0;
    forever begin
      @(negedge aclk);
      ar_hs  = arvalid && arready;
      r_hs   = rvalid && rready;
      rst    = areset;
      a_addr = araddr;
      a_len  = int'(arlen);
      @(posedge aclk);
      #1;
      cyc++;
      if (rst) begin
        pend_addr.delete();
        pend_last.delete();
      end else begin
        if (r_hs && pend_addr.size() > 0) begin
          void'(pend_addr.pop_front());
          void'(pend_last.pop_front());
        end
        if (ar_hs) begin
          for (int i = 0; i <= a_len; i++) begin
            pend_addr.push_back(a_addr + 64'(8 * i));
            pend_last.push_back(i == a_len);
          end
        end
      end
      arready  = (ar_mode == 1) || (ar_mode == 2 && cyc % 2 == 0);
      m_tready = (m_mode == 1) || (m_mode == 2 && cyc % 3 != 0);
      if (pend_addr.size() > 0 && !(ar_mode == 2 && cyc % 4 == 1)) begin
        rvalid = 1'b1;
        rdata  = mdata(pend_addr[0]);
        rlast  = pend_last[0];
        rresp  = (pend_addr[0] == err_addr) ? 2'b10 : 2'b00;
      end else begin
        rvalid = 1'b0;
        rdata  = '0;
        rlast  = 1'b0;
        rresp  = 2'b00;
      end
    end
  end

  // Transfer-level model and per-cycle comparison
  initial begin
    bit          rst_seen, busy, done_exp, done_next;
    int          fifo_cnt, issued, popped;
    logic [63:0] exp_ar_addr[$];
    int          exp_ar_len[$];
    logic [63:0] exp_data[$];
    logic [63:0] l64, nb, rem, bl;
    rst_seen = 1'b1;
    busy = 1'b0;
    done_exp = 1'b0;
    fifo_cnt = 0;
    issued = 0;
    popped = 0;
    forever begin
      @(negedge aclk);
      if (rst_seen) begin
        chk("rst_arvalid", 64'(arvalid), 0);
        chk("rst_araddr", araddr, 0);
        chk("rst_arlen", 64'(arlen), 0);
        chk("rst_done", 64'(ctrl_done), 0);
        chk("rst_tvalid", 64'(m_tvalid), 0);
        chk("rst_rready", 64'(rready), 0);
      end else begin
        chk("tvalid", 64'(m_tvalid), 64'(fifo_cnt != 0));
        chk("done", 64'(ctrl_done), 64'(done_exp));
        chk("rready", 64'(rready), 1);
        chk("arsize", 64'(arsize), 3);
        if (!rready) rready_low_cnt++;
        if (ctrl_done) done_cnt++;
        if (m_tvalid && m_tready) begin
          beat_cnt++;
          if (exp_data.size() == 0) chk("extra_beat", 1, 0);
          else chk("tdata", m_tdata, exp_data[0]);
        end
        if (arvalid && arready) begin
          ar_cnt++;
          ar_log_addr.push_back(araddr);
          ar_log_len.push_back(int'(arlen));
          if (exp_ar_addr.size() == 0) begin
            chk("extra_ar", 1, 0);
          end else begin
            chk("araddr", araddr, exp_ar_addr[0]);
            chk("arlen", 64'(arlen), 64'(exp_ar_len[0]));
            issued += exp_ar_len[0] + 1;
            chk("credit_bound", 64'((issued - popped) <= 512), 1);
          end
        end
      end
      // advance model over the coming edge
      done_next = 1'b0;
      if (areset) begin
        busy = 1'b0;
        fifo_cnt = 0;
        exp_ar_addr.delete();
        exp_ar_len.delete();
        exp_data.delete();
      end else begin
        if (rvalid && rready) fifo_cnt++;
        if (m_tvalid && m_tready && exp_data.size() > 0) begin
          void'(exp_data.pop_front());
          fifo_cnt--;
          popped++;
          if (busy && exp_data.size() == 0) done_next = 1'b1;
        end
        if (arvalid && arready && exp_ar_addr.size() > 0) begin
          void'(exp_ar_addr.pop_front());
          void'(exp_ar_len.pop_front());
        end
        if (done_exp) busy = 1'b0;
        else if (ctrl_start && !busy) begin
          busy = 1'b1;
          issued = 0;
          popped = 0;
          l64 = 64'(ctrl_length);
          nb  = (l64 + 255) / 256;
          rem = l64 % 256;
          for (longint unsigned i = 0; i < nb; i++) begin
            bl = (i == nb - 1 && rem != 0) ? rem : 64'd256;
            exp_ar_addr.push_back(ctrl_offset + 64'(i * 2048));
            exp_ar_len.push_back(int'(bl) - 1);
          end
          for (longint unsigned k = 0; k < l64; k++) exp_data.push_back(mdata(ctrl_offset + 64'(8 * k)));
          if (l64 == 0) done_next = 1'b1;
        end
      end
      done_exp = done_next;
      rst_seen = areset;
    end
  end

  task automatic clear_logs();
    ar_cnt = 0;
    beat_cnt = 0;
    done_cnt = 0;
    rready_low_cnt = 0;
    ar_log_addr.delete();
    ar_log_len.delete();
  endtask

  task automatic start_xfer(input logic [63:0] off, input logic [31:0] len);
    clear_logs();
    ctrl_offset = off;
    ctrl_length = len;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    if (done_cnt == 0) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL %s: no ctrl_done within %0d cycles", name, budget);
    end
    repeat (3) tick();
  endtask

  initial begin
    int n;
    repeat (3) tick();
    areset = 1'b0;
    repeat (2) tick();

    // single beat
    start_xfer(64'h1000, 1);
    wait_done("A_done", 100);
    chk("A_ar_cnt", 64'(ar_cnt), 1);
    chk("A_araddr", ar_log_addr[0], 64'h1000);
    chk("A_arlen", 64'(ar_log_len[0]), 0);
    chk("A_beats", 64'(beat_cnt), 1);
    chk("A_done_cnt", 64'(done_cnt), 1);

    // three bursts, last one partial
    start_xfer(64'h20000, 600);
    wait_done("B_done", 2000);
    chk("B_ar_cnt", 64'(ar_cnt), 3);
    chk("B_arlen0", 64'(ar_log_len[0]), 255);
    chk("B_arlen2", 64'(ar_log_len[2]), 87);
    chk("B_addr1", ar_log_addr[1], 64'h20800);
    chk("B_addr2", ar_log_addr[2], 64'h21000);
    chk("B_beats", 64'(beat_cnt), 600);
    chk("B_done_cnt", 64'(done_cnt), 1);

    // backpressure: only two bursts fit until the stream drains
    m_mode = 0;
    start_xfer(64'h40000, 1024);
    repeat (600) tick();
    chk("C_ar_held", 64'(ar_cnt), 2);
    chk("C_no_beats", 64'(beat_cnt), 0);
    m_mode = 1;
    wait_done("C_done", 3000);
    chk("C_ar_cnt", 64'(ar_cnt), 4);
    chk("C_addr3", ar_log_addr[3], 64'h41800);
    chk("C_beats", 64'(beat_cnt), 1024);
    chk("C_rready_low", 64'(rready_low_cnt), 0);

    // zero length
    start_xfer(64'h9000, 0);
    @(negedge aclk);
    chk("D_done_hi", 64'(ctrl_done), 1);
    tick();
    @(negedge aclk);
    chk("D_done_lo", 64'(ctrl_done), 0);
    repeat (5) tick();
    chk("D_ar_cnt", 64'(ar_cnt), 0);
    chk("D_beats", 64'(beat_cnt), 0);
    chk("D_done_cnt", 64'(done_cnt), 1);

    // abort mid-transfer, then a fresh short transfer
    start_xfer(64'h80000, 300);
    n = 0;
    while (beat_cnt < 100 && n < 1000) begin
      tick();
      n++;
    end
    chk("E_reached_100", 64'(beat_cnt >= 100), 1);
    areset = 1'b1;
    tick();
    @(negedge aclk);
    chk("E_arvalid", 64'(arvalid), 0);
    chk("E_tvalid", 64'(m_tvalid), 0);
    chk("E_done", 64'(ctrl_done), 0);
    chk("E_rready", 64'(rready), 0);
    tick();
    areset = 1'b0;
    repeat (2) tick();
    start_xfer(64'h3000, 4);
    wait_done("E2_done", 200);
    chk("E2_ar_cnt", 64'(ar_cnt), 1);
    chk("E2_arlen", 64'(ar_log_len[0]), 3);
    chk("E2_beats", 64'(beat_cnt), 4);

    // irregular handshakes on every channel
    ar_mode = 2;
    m_mode = 2;
    start_xfer(64'h100000, 520);
    wait_done("F_done", 4000);
    chk("F_ar_cnt", 64'(ar_cnt), 3);
    chk("F_arlen2", 64'(ar_log_len[2]), 7);
    chk("F_beats", 64'(beat_cnt), 520);
    ar_mode = 1;
    m_mode = 1;

`ifdef KRNL_CARD_RTL_RRESP_ERR_EN
    err_addr = 64'h5000 + 64'd40;
    start_xfer(64'h5000, 8);
    wait_done("G_done", 200);
    chk("G_err_set", 64'(rresp_err), 1);
    repeat (5) tick();
    chk("G_err_held", 64'(rresp_err), 1);
    err_addr = '1;
    start_xfer(64'h6000, 2);
    @(negedge aclk);
    chk("G_err_clr", 64'(rresp_err), 0);
    wait_done("G2_done", 200);
    chk("G2_err", 64'(rresp_err), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
